// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter that merges EX results and load returns onto the single regfile
// write port, plus a load scoreboard that lets decode stall on RAW/WAW hazards.
module rf_wb_arbiter #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [AW-1:0]   ex_rd,
   input  logic [XLEN-1:0] ex_data,
   input  logic            ld_issue,
   input  logic [AW-1:0]   ld_issue_rd,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [AW-1:0]   ld_rd,
   input  logic [XLEN-1:0] ld_data,
   output logic            rf_wen,
   output logic [AW-1:0]   rf_rd,
   output logic [XLEN-1:0] rf_wdata,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            sb_err
);

   typedef enum logic {GRANT_EX = 1'b0, GRANT_LD = 1'b1} grant_e;

   grant_e          last_grant_q, last_grant_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic            rf_wen_q, rf_wen_d;
   logic [AW-1:0]   rf_rd_q, rf_rd_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic            sb_err_q, sb_err_d;

   logic ex_hit, ld_hit, issue_hit;
   logic ex_elig, ld_elig, contended;
   logic ex_grant, ld_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= GRANT_EX;
         busy_q       <= '0;
         rf_wen_q     <= 1'b0;
         rf_rd_q      <= '0;
         rf_wdata_q   <= '0;
         sb_err_q     <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
         rf_wen_q     <= rf_wen_d;
         rf_rd_q      <= rf_rd_d;
         rf_wdata_q   <= rf_wdata_d;
         sb_err_q     <= sb_err_d;
      end
   end

   // An EX request blocked by an older load is not a contender, so LD wins alone.
   always_comb begin
      ex_hit    = (ex_rd != '0);
      ld_hit    = (ld_rd != '0);
      issue_hit = (ld_issue_rd != '0);
      ex_elig   = ex_valid & ex_hit & ~busy_q[ex_rd];
      ld_elig   = ld_valid & ld_hit;
      contended = ex_elig & ld_elig;
      ex_grant  = ex_elig & (~ld_elig | (last_grant_q == GRANT_LD));
      ld_grant  = ld_elig & (~ex_elig | (last_grant_q == GRANT_EX));
   end

   always_comb begin
      last_grant_d = last_grant_q;
      busy_d       = busy_q;
      rf_wen_d     = ex_grant | ld_grant;
      rf_rd_d      = rf_rd_q;
      rf_wdata_d   = rf_wdata_q;
      sb_err_d     = sb_err_q;

      if (contended) begin
         last_grant_d = ex_grant ? GRANT_EX : GRANT_LD;
      end

      if (ld_grant) begin
         rf_rd_d    = ld_rd;
         rf_wdata_d = ld_data;
      end else if (ex_grant) begin
         rf_rd_d    = ex_rd;
         rf_wdata_d = ex_data;
      end

      // Clear first so a same-index issue in the same cycle leaves the register busy.
      if (ld_grant) begin
         busy_d[ld_rd] = 1'b0;
      end
      if (ld_issue & issue_hit) begin
         busy_d[ld_issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;

      if ((ld_issue & issue_hit & busy_q[ld_issue_rd]) | (ld_grant & ~busy_q[ld_rd])) begin
         sb_err_d = 1'b1;
      end
   end

   always_comb begin
      ex_ready = (ex_valid & ~ex_hit) | ex_grant;
      ld_ready = (ld_valid & ~ld_hit) | ld_grant;
      rf_wen   = rf_wen_q;
      rf_rd    = rf_rd_q;
      rf_wdata = rf_wdata_q;
      sb_err   = sb_err_q;
      rs1_busy = (rs1 != '0) & (busy_q[rs1] | (rf_wen_q & (rf_rd_q == rs1)));
      rs2_busy = (rs2 != '0) & (busy_q[rs2] | (rf_wen_q & (rf_rd_q == rs2)));
   end

endmodule
